knn_controller: RTL
===================

// Module: knn_controller
// PURPOSE
//  Top-level sequencer for one KNN classification. Steps the distance calculator over all L training
//  samples, starts the distance sorter, then majority-votes the types of the K nearest samples.
//  Sits between the host (start/ready/read) and the distance_calculator / distance_sort datapath.
// PARAMETERS
//  L      15   number of training samples; must satisfy K <= L, else elaboration error
//  K      7    number of nearest neighbours voted; must be 1 <= K
//  W      32   width of distance and type words
//  C      4    number of classes; valid types are 0..C-1
//  IDX_W  $clog2(L)  width of the sample index
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  start        in   1      host request; sampled only while ready=1
//  ready        out  1      1 only in IDLE
//  dist_req     out  1      one-cycle pulse: compute distance of sample dist_idx
//  dist_idx     out  IDX_W  training sample index, held from dist_req until dist_valid
//  dist_valid   in   1      calculator result for dist_idx written into the distance array
//  sort_start   out  1      one-cycle pulse: sort all L distances
//  sort_done    in   1      one-cycle pulse: sorted arrays stable
//  vote_idx     out  IDX_W  read address into type_array_sorted (0 = nearest)
//  vote_type    in   W      type_array_sorted[vote_idx], combinational read
//  result_type  out  W      winning class, zero-extended
//  result_valid out  1      result held until read
//  read         in   1      host consumes result
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, dist_req=0, dist_idx=0, sort_start=0, vote_idx=0, result_type=0,
//   result_valid=0, all class counters 0. All outputs registered.
//  rst wins over every other input, in any state. Mid-operation: abort, return to IDLE next cycle,
//   no result produced.
//  FSM:
//   IDLE     start=1 -> CALC_REQ; dist_idx=0, counters cleared, ready=0.
//   CALC_REQ dist_req=1 for exactly one cycle -> CALC_WAIT.
//   CALC_WAIT dist_valid=1: if dist_idx==L-1 -> SORT_REQ, else dist_idx++ and -> CALC_REQ.
//             Waits indefinitely for dist_valid (no timeout).
//   SORT_REQ sort_start=1 for one cycle -> SORT_WAIT.
//   SORT_WAIT sort_done=1 -> VOTE; vote_idx=0.
//   VOTE     one neighbour per cycle: if vote_type < C, count[vote_type]++; a type >= C is ignored
//            (no count). vote_idx==K-1 -> DECIDE, else vote_idx++.
//   DECIDE   result_type = argmax(count). Ties go to the lowest class index.
//            result_valid=1 -> DONE.
//   DONE     hold result. When read=1: result_valid=0 next cycle -> IDLE, ready=1.
//  Ignored inputs: start outside IDLE, including in the same cycle as read in DONE (no queuing).
//   dist_valid outside CALC_WAIT, sort_done outside SORT_WAIT.
//  Same-cycle response: dist_valid arriving in the same cycle dist_req is high is not accepted.
//   The calculator responds no earlier than the cycle after dist_req.
//  Counters: $clog2(K+1) bits each; cannot overflow since total count <= K.
//  Latency: for calculator latency Dc (cycles from dist_req to dist_valid) and sorter latency Ds
//   (cycles from sort_start to sort_done), start to result_valid rise = 1 + L*(1+Dc) + (1+Ds) + K + 1 cycles.
// STRUCTURE
//  Shared package knn_pkg: state enum (IDLE, CALC_REQ, CALC_WAIT, SORT_REQ, SORT_WAIT, VOTE, DECIDE,
//   DONE) and default constants for L, K, W, C.
//  One sub-module, knn_vote_counter: C counters with clear/inc inputs and a combinational
//   lowest-index-wins argmax.
//  FSM, dist_idx and vote_idx counters stay in knn_controller.
// TESTING (L=15, K=7, C=4; calculator Dc=1, sorter Ds=3 models)
//  1. Reset then start: 15 dist_req pulses with dist_idx 0..14, one sort_start. Sorted types
//     [2,2,1,2,0,1,3,...] -> result_type=2, result_valid rises 1+30+4+7+1=43 cycles after start.
//  2. Tie: sorted types [1,0,1,0,3,3,2] (counts 2,2,1,2) -> result_type=0.
//  3. Out-of-range: sorted types [7,7,7,1,5,5,5] -> only class 1 counted -> result_type=1.
//  4. rst asserted in CALC_WAIT at dist_idx=5 -> next cycle IDLE, ready=1, no result_valid.
//     Fresh start restarts at dist_idx=0.
//  5. start pulsed during SORT_WAIT and in the same cycle as read -> ignored.
//     Exactly one classification per accepted start; ready returns 1 the cycle after read.
//  6. read held 0 for 20 cycles in DONE -> result_type/result_valid stable.
//     Spurious dist_valid in IDLE and spurious sort_done in VOTE -> no state change.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared types and default sizing for the KNN classification controller.
package knn_pkg;

  localparam int L_DEF     = 15;
  localparam int K_DEF     = 7;
  localparam int W_DEF     = 32;
  localparam int C_DEF     = 4;
  localparam int IDX_W_DEF = $clog2(L_DEF);

  typedef enum logic [2:0] {
    IDLE,
    CALC_REQ,
    CALC_WAIT,
    SORT_REQ,
    SORT_WAIT,
    VOTE,
    DECIDE,
    DONE
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/knn_if.sv
// Host and datapath signals of the KNN controller; master = controller side.
interface knn_if
  import knn_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int W     = W_DEF
) ();

  logic             start;
  logic             ready;
  logic             dist_req;
  logic [IDX_W-1:0] dist_idx;
  logic             dist_valid;
  logic             sort_start;
  logic             sort_done;
  logic [IDX_W-1:0] vote_idx;
  logic [W-1:0]     vote_type;
  logic [W-1:0]     result_type;
  logic             result_valid;
  logic             read;

  modport master (
    input  start, dist_valid, sort_done, vote_type, read,
    output ready, dist_req, dist_idx, sort_start, vote_idx, result_type, result_valid
  );

  modport slave (
    output start, dist_valid, sort_done, vote_type, read,
    input  ready, dist_req, dist_idx, sort_start, vote_idx, result_type, result_valid
  );

endinterface

// File: rtl/knn_vote_counter.sv
// Per-class vote counters with clear/increment and a lowest-index-wins argmax.
module knn_vote_counter
  import knn_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int C     = C_DEF,
  parameter int CLS_W = idx_width(C)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CLS_W-1:0] inc_cls,
  output logic [CLS_W-1:0] win_cls
);

  localparam int CNT_W = $clog2(K + 1);

  logic [CNT_W-1:0] cnt_q [C];
  logic [CNT_W-1:0] cnt_d [C];

  always_comb begin
    for (int c = 0; c < C; c++) begin
      cnt_d[c] = cnt_q[c];
      if (clr) begin
        cnt_d[c] = '0;
      end else if (inc && (inc_cls == CLS_W'(c))) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < C; c++) begin
      if (rst) cnt_q[c] <= '0;
      else     cnt_q[c] <= cnt_d[c];
    end
  end

  // Strict greater-than keeps the lower class on ties.
  always_comb begin
    win_cls = '0;
    for (int c = 1; c < C; c++) begin
      if (cnt_q[c] > cnt_q[win_cls]) win_cls = CLS_W'(c);
    end
  end

endmodule

// File: rtl/knn_controller.sv
// Sequences one KNN classification: L distance requests, one sort, then a K-neighbour majority vote.
module knn_controller
  import knn_pkg::*;
#(
  parameter int L     = L_DEF,
  parameter int K     = K_DEF,
  parameter int W     = W_DEF,
  parameter int C     = C_DEF,
  parameter int IDX_W = $clog2(L)
) (
  input  logic   clk,
  input  logic   rst,
  knn_if.master  bus
);

  if (K < 1 || K > L) begin : g_bad_k
    $error("knn_controller: K must satisfy 1 <= K <= L");
  end

  localparam int CLS_W = idx_width(C);

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             dist_req_q, dist_req_d;
  logic [IDX_W-1:0] dist_idx_q, dist_idx_d;
  logic             sort_start_q, sort_start_d;
  logic [IDX_W-1:0] vote_idx_q, vote_idx_d;
  logic [W-1:0]     result_type_q, result_type_d;
  logic             result_valid_q, result_valid_d;

  logic             cnt_clr;
  logic             cnt_inc;
  logic [CLS_W-1:0] win_cls;
  logic             type_in_range;

  assign type_in_range = (bus.vote_type < W'(C));

  knn_vote_counter #(.K(K), .C(C), .CLS_W(CLS_W)) u_vote (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .inc_cls (bus.vote_type[CLS_W-1:0]),
    .win_cls (win_cls)
  );

  always_comb begin
    state_d        = state_q;
    ready_d        = ready_q;
    dist_req_d     = 1'b0;
    dist_idx_d     = dist_idx_q;
    sort_start_d   = 1'b0;
    vote_idx_d     = vote_idx_q;
    result_type_d  = result_type_q;
    result_valid_d = result_valid_q;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;

    // Pulse outputs are raised on the transition into their state so they align with it.
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = CALC_REQ;
          dist_idx_d = '0;
          cnt_clr    = 1'b1;
          ready_d    = 1'b0;
          dist_req_d = 1'b1;
        end
      end
      CALC_REQ: state_d = CALC_WAIT;
      CALC_WAIT: begin
        if (bus.dist_valid) begin
          if (dist_idx_q == IDX_W'(L - 1)) begin
            state_d      = SORT_REQ;
            sort_start_d = 1'b1;
          end else begin
            dist_idx_d = dist_idx_q + 1'b1;
            state_d    = CALC_REQ;
            dist_req_d = 1'b1;
          end
        end
      end
      SORT_REQ: state_d = SORT_WAIT;
      SORT_WAIT: begin
        if (bus.sort_done) begin
          state_d    = VOTE;
          vote_idx_d = '0;
        end
      end
      VOTE: begin
        cnt_inc = type_in_range;
        if (vote_idx_q == IDX_W'(K - 1)) state_d = DECIDE;
        else                             vote_idx_d = vote_idx_q + 1'b1;
      end
      DECIDE: begin
        result_type_d  = W'(win_cls);
        result_valid_d = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        if (bus.read) begin
          result_valid_d = 1'b0;
          ready_d        = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ready_q        <= 1'b1;
      dist_req_q     <= 1'b0;
      dist_idx_q     <= '0;
      sort_start_q   <= 1'b0;
      vote_idx_q     <= '0;
      result_type_q  <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      dist_req_q     <= dist_req_d;
      dist_idx_q     <= dist_idx_d;
      sort_start_q   <= sort_start_d;
      vote_idx_q     <= vote_idx_d;
      result_type_q  <= result_type_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.ready        = ready_q;
  assign bus.dist_req     = dist_req_q;
  assign bus.dist_idx     = dist_idx_q;
  assign bus.sort_start   = sort_start_q;
  assign bus.vote_idx     = vote_idx_q;
  assign bus.result_type  = result_type_q;
  assign bus.result_valid = result_valid_q;

endmodule
